// File: rtl/lbw_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lbw_pkg
// Description : Shared FSM states, widths and burst address helper for
//               line_burst_writer.
// Revision    : 1.0 - initial release
// ============================================================================
package lbw_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned ADDR_W = 28;

    typedef enum logic [1:0] {
        R_IDLE   = 2'd0,
        R_LINE   = 2'd1,
        R_COMMIT = 2'd2
    } rd_state_t;

    typedef enum logic [1:0] {
        W_IDLE = 2'd0,
        W_REQ  = 2'd1,
        W_DATA = 2'd2,
        W_WAIT = 2'd3
    } wr_state_t;

    // Byte address of a burst inside a line; 2 bytes per pixel, wraps at 2^ADDR_W.
    function automatic logic [ADDR_W-1:0] lbw_burst_addr(
        input logic [31:0] base,
        input logic [31:0] row,
        input logic [31:0] hact,
        input logic [31:0] burst,
        input logic [31:0] blen
    );
        return ADDR_W'(base + 32'd2 * (row * hact + burst * 32'd2 * blen));
    endfunction

endpackage
`default_nettype wire

// File: rtl/lbw_line_ram.sv
`default_nettype none
// ============================================================================
// Module      : lbw_line_ram
// Description : Simple dual-port line bank, one write port, one read port
//               with a registered 1-cycle read that holds when not read.
// Revision    : 1.0 - initial release
// ============================================================================
module lbw_line_ram #(
    parameter int unsigned DEPTH = 640,
    parameter int unsigned AW    = 10,
    parameter int unsigned DW    = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  logic [DW-1:0] wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output logic [DW-1:0] rdata_o
);

    logic [DW-1:0] mem_q [DEPTH];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule
`default_nettype wire

// File: rtl/line_burst_writer.sv
`default_nettype none
// ============================================================================
// Module      : line_burst_writer
// Description : Buffers camera lines into a bank and drains each line to
//               memory as fixed-length 32-bit bursts. Define LBW_PINGPONG_EN
//               for two banks (read one line while the other drains).
// Revision    : 1.0 - initial release
// ============================================================================
module line_burst_writer
    import lbw_pkg::*;
#(
    parameter int unsigned H_ACT     = 1280,
    parameter int unsigned V_ACT     = 720,
    parameter int unsigned BURST_LEN = 16,
    parameter int unsigned BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              aquire,
    output logic              read_en,
    input  logic [15:0]       cam_data,
    input  logic [10:0]       cam_row,
    output logic              wr_req,
    output logic [ADDR_W-1:0] wr_addr,
    input  logic              wr_ack,
    input  logic              wr_dreq,
    output logic [WORD_W-1:0] wr_data,
    input  logic              wr_done,
    output logic              frame_done,
    output logic              busy
);

`ifdef LBW_PINGPONG_EN
    localparam int unsigned NBANK = 2;
`else
    localparam int unsigned NBANK = 1;
`endif
    localparam int unsigned WORDS  = H_ACT / 2;
    localparam int unsigned AW     = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int unsigned NBURST = H_ACT / (2 * BURST_LEN);
    localparam int unsigned BW     = (NBURST > 1) ? $clog2(NBURST) : 1;
    localparam int unsigned CW     = $clog2(BURST_LEN + 1);
    localparam int unsigned PW     = $clog2(H_ACT + 1);

    rd_state_t         rd_state_q, rd_state_d;
    logic [PW-1:0]     pix_cnt_q, pix_cnt_d;
    logic              cap_vld_q;
    logic [PW-1:0]     cap_idx_q;
    logic [15:0]       pix_lo_q;
    logic              fill_ptr_q, fill_ptr_d;
    logic [1:0]        full_q, full_d;
    logic [10:0]       tag_q [2];
    logic              tag_we;
    logic              line_commit;

    wr_state_t         wr_state_q, wr_state_d;
    logic              drain_ptr_q, drain_ptr_d;
    logic [BW-1:0]     burst_q, burst_d;
    logic [CW-1:0]     word_cnt_q, word_cnt_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic              frame_done_q, frame_done_d;
    logic              rsel_q;
    logic              bank_free;
    logic              ram_re;

    logic              ram_we;
    logic [AW-1:0]     ram_waddr;
    logic [WORD_W-1:0] ram_wdata;
    logic [AW-1:0]     ram_raddr;
    logic [WORD_W-1:0] ram_q [2];

    // ---------------- read (fill) side ----------------
    always_comb begin
        rd_state_d  = rd_state_q;
        pix_cnt_d   = pix_cnt_q;
        fill_ptr_d  = fill_ptr_q;
        tag_we      = 1'b0;
        line_commit = 1'b0;
        read_en     = 1'b0;
        case (rd_state_q)
            R_IDLE: begin
                if (aquire && !full_q[fill_ptr_q]) begin
                    tag_we     = 1'b1;
                    pix_cnt_d  = '0;
                    rd_state_d = R_LINE;
                end
            end
            R_LINE: begin
                // Pops run unbroken; a gap would make upstream skip a row.
                if (pix_cnt_q < PW'(H_ACT)) begin
                    read_en   = 1'b1;
                    pix_cnt_d = pix_cnt_q + 1'b1;
                end
                if (cap_vld_q && (cap_idx_q == PW'(H_ACT - 1))) begin
                    rd_state_d = R_COMMIT;
                end
            end
            R_COMMIT: begin
                line_commit = 1'b1;
                fill_ptr_d  = (NBANK == 2) ? ~fill_ptr_q : 1'b0;
                rd_state_d  = R_IDLE;
            end
            default: rd_state_d = R_IDLE;
        endcase
    end

    assign ram_we    = cap_vld_q && cap_idx_q[0];
    assign ram_waddr = AW'(cap_idx_q >> 1);
    assign ram_wdata = {cam_data, pix_lo_q};

    // ---------------- write (drain) side ----------------
    always_comb begin
        wr_state_d   = wr_state_q;
        drain_ptr_d  = drain_ptr_q;
        burst_d      = burst_q;
        word_cnt_d   = word_cnt_q;
        wr_addr_d    = wr_addr_q;
        frame_done_d = 1'b0;
        bank_free    = 1'b0;
        ram_re       = 1'b0;
        case (wr_state_q)
            W_IDLE: begin
                if (full_q[drain_ptr_q]) begin
                    burst_d    = '0;
                    wr_addr_d  = lbw_burst_addr(BASE_ADDR, 32'(tag_q[drain_ptr_q]),
                                                H_ACT, 32'd0, BURST_LEN);
                    wr_state_d = W_REQ;
                end
            end
            W_REQ: begin
                if (wr_ack) begin
                    word_cnt_d = '0;
                    wr_state_d = W_DATA;
                end
            end
            W_DATA: begin
                if (wr_dreq) begin
                    ram_re     = 1'b1;
                    word_cnt_d = word_cnt_q + 1'b1;
                    if (word_cnt_q == CW'(BURST_LEN - 1)) begin
                        wr_state_d = W_WAIT;
                    end
                end
            end
            W_WAIT: begin
                if (wr_done) begin
                    if (burst_q == BW'(NBURST - 1)) begin
                        bank_free    = 1'b1;
                        frame_done_d = (tag_q[drain_ptr_q] == 11'(V_ACT - 1));
                        drain_ptr_d  = (NBANK == 2) ? ~drain_ptr_q : 1'b0;
                        wr_state_d   = W_IDLE;
                    end else begin
                        burst_d    = burst_q + 1'b1;
                        wr_addr_d  = lbw_burst_addr(BASE_ADDR, 32'(tag_q[drain_ptr_q]),
                                                    H_ACT, 32'(burst_q) + 32'd1, BURST_LEN);
                        wr_state_d = W_REQ;
                    end
                end
            end
            default: wr_state_d = W_IDLE;
        endcase
    end

    assign ram_raddr = AW'(32'(burst_q) * BURST_LEN + 32'(word_cnt_q));

    // Set and clear never hit the same bank: a filling bank is never full.
    always_comb begin
        full_d = full_q;
        if (line_commit) begin
            full_d[fill_ptr_q] = 1'b1;
        end
        if (bank_free) begin
            full_d[drain_ptr_q] = 1'b0;
        end
    end

    // ---------------- registers ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_state_q   <= R_IDLE;
            pix_cnt_q    <= '0;
            cap_vld_q    <= 1'b0;
            cap_idx_q    <= '0;
            pix_lo_q     <= '0;
            fill_ptr_q   <= 1'b0;
            full_q       <= '0;
            tag_q[0]     <= '0;
            tag_q[1]     <= '0;
            wr_state_q   <= W_IDLE;
            drain_ptr_q  <= 1'b0;
            burst_q      <= '0;
            word_cnt_q   <= '0;
            wr_addr_q    <= '0;
            frame_done_q <= 1'b0;
            rsel_q       <= 1'b0;
        end else begin
            rd_state_q   <= rd_state_d;
            pix_cnt_q    <= pix_cnt_d;
            cap_vld_q    <= read_en;
            cap_idx_q    <= pix_cnt_q;
            if (cap_vld_q && !cap_idx_q[0]) begin
                pix_lo_q <= cam_data;
            end
            fill_ptr_q   <= fill_ptr_d;
            full_q       <= full_d;
            if (tag_we) begin
                tag_q[fill_ptr_q] <= cam_row;
            end
            wr_state_q   <= wr_state_d;
            drain_ptr_q  <= drain_ptr_d;
            burst_q      <= burst_d;
            word_cnt_q   <= word_cnt_d;
            wr_addr_q    <= wr_addr_d;
            frame_done_q <= frame_done_d;
            if (ram_re) begin
                rsel_q <= drain_ptr_q;
            end
        end
    end

    // ---------------- bank storage ----------------
    for (genvar b = 0; b < 2; b++) begin : g_bank
        if (b < NBANK) begin : g_ram
            lbw_line_ram #(
                .DEPTH (WORDS),
                .AW    (AW),
                .DW    (WORD_W)
            ) u_ram (
                .clk     (clk),
                .rst     (rst),
                .we_i    (ram_we && (fill_ptr_q == 1'(b))),
                .waddr_i (ram_waddr),
                .wdata_i (ram_wdata),
                .re_i    (ram_re && (drain_ptr_q == 1'(b))),
                .raddr_i (ram_raddr),
                .rdata_o (ram_q[b])
            );
        end else begin : g_none
            assign ram_q[b] = '0;
        end
    end

    // rsel_q only moves on a real read, so wr_data holds between pulls.
    assign wr_data    = ram_q[rsel_q];
    assign wr_req     = (wr_state_q == W_REQ);
    assign wr_addr    = wr_addr_q;
    assign frame_done = frame_done_q;
    assign busy       = (|full_q) || (rd_state_q != R_IDLE) || (wr_state_q != W_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_line_burst_writer.sv
`default_nettype none
// ============================================================================
// Module      : tb_line_burst_writer
// Description : Randomised scoreboard bench for line_burst_writer; the model
//               derives burst addresses and words from each captured line.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_line_burst_writer;

    localparam int H    = 128;
    localparam int V    = 4;
    localparam int BL   = 16;
    localparam int NB   = H / (2 * BL);
    localparam logic [31:0] BASE = 32'h0FFF_FF00;

    logic        clk = 1'b0;
    logic        rst;
    logic        aquire;
    logic        read_en;
    logic [15:0] cam_data;
    logic [10:0] cam_row;
    logic        wr_req;
    logic [27:0] wr_addr;
    logic        wr_ack;
    logic        wr_dreq;
    logic [31:0] wr_data;
    logic        wr_done;
    logic        frame_done;
    logic        busy;

    int n_tests = 0;
    int n_fail  = 0;
    int frames_seen = 0;
    int exp_frames  = 0;
    int reads_in_wait = 0;
    bit sink_waiting = 1'b0;

    logic [27:0] exp_addr_q [$];
    bit          exp_last_q [$];
    logic [31:0] exp_word_q [$];
    logic [15:0] line_pix   [$];

    always #5 clk = ~clk;

    line_burst_writer #(
        .H_ACT     (H),
        .V_ACT     (V),
        .BURST_LEN (BL),
        .BASE_ADDR (BASE)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .aquire     (aquire),
        .read_en    (read_en),
        .cam_data   (cam_data),
        .cam_row    (cam_row),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_ack     (wr_ack),
        .wr_dreq    (wr_dreq),
        .wr_data    (wr_data),
        .wr_done    (wr_done),
        .frame_done (frame_done),
        .busy       (busy)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] req);
        n_tests++;
        if (got !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", name, got, req);
        end
    endtask

    task automatic timeout_fail(input string name, input int cycles);
        n_tests++;
        n_fail++;
        $display("FAIL %s: no response within %0d cycles", name, cycles);
    endtask

    // Reference: a finished line becomes NB bursts of BL words, two pixels per word.
    task automatic model_line(input int row);
        logic [31:0] a;
        int k;
        for (int b = 0; b < NB; b++) begin
            a = BASE + 32'd2 * (32'(row) * H + 32'(b) * 2 * BL);
            exp_addr_q.push_back(a[27:0]);
            exp_last_q.push_back((row == V - 1) && (b == NB - 1));
            for (int j = 0; j < BL; j++) begin
                k = b * BL + j;
                exp_word_q.push_back({line_pix[2*k+1], line_pix[2*k]});
            end
        end
        if (row == V - 1) exp_frames++;
    endtask

    task automatic upstream_run(input int nrows, input int row0);
        int row, done, cyc, run;
        bit pend, prev;
        row = row0; done = 0; cyc = 0; run = 0; pend = 1'b0; prev = 1'b0;
        line_pix.delete();
        cam_row = 11'(row);
        aquire  = 1'b1;
        while (done < nrows && cyc < 30000) begin
            @(negedge clk);
            cyc++;
            if (pend) begin
                cam_data = 16'($urandom);
                line_pix.push_back(cam_data);
                if (line_pix.size() == H) begin
                    model_line(row);
                    line_pix.delete();
                    done++;
                    row++;
                    cam_row = 11'(row);
                    if (done == nrows) aquire = 1'b0;
                end
            end
            pend = read_en;
            if (read_en) begin
                run++;
                if (sink_waiting) reads_in_wait++;
            end else if (prev) begin
                check("read_en_run_length", run, H);
                run = 0;
            end
            prev = read_en;
        end
        if (done < nrows) timeout_fail("upstream_lines", cyc);
        aquire = 1'b0;
    endtask

    task automatic sink_run(input int nbursts, input int ack_delay0, input bit slow, input int stop_word);
        logic [27:0] a_exp;
        logic [31:0] w_exp;
        bit last;
        int t, d, unstable, gap;
        w_exp = '0;
        for (int n = 0; n < nbursts; n++) begin
            t = 0;
            while (!wr_req && t < 5000) begin
                @(negedge clk);
                t++;
            end
            if (!wr_req) begin
                timeout_fail("wr_req_wait", t);
                return;
            end
            a_exp = exp_addr_q.pop_front();
            last  = exp_last_q.pop_front();
            check("wr_addr", 32'(wr_addr), 32'(a_exp));
            d = (n == 0) ? ack_delay0 : int'($urandom_range(0, 3));
            unstable = 0;
            repeat (d) begin
                @(negedge clk);
                if (!wr_req || wr_addr !== a_exp) unstable++;
            end
            check("req_addr_stable", unstable, 0);
            wr_ack = 1'b1;
            @(negedge clk);
            wr_ack = 1'b0;
            check("req_drop_after_ack", 32'(wr_req), 0);
            for (int j = 0; j < BL; j++) begin
                gap = int'($urandom_range(0, 2));
                if (gap != 0) begin
                    wr_dreq = 1'b0;
                    repeat (gap) @(negedge clk);
                end
                wr_dreq = 1'b1;
                @(negedge clk);
                w_exp = exp_word_q.pop_front();
                check("wr_data", wr_data, w_exp);
                if (stop_word > 0 && j + 1 == stop_word) begin
                    wr_dreq = 1'b0;
                    return;
                end
            end
            // Extra pulls while waiting for commit must be ignored.
            wr_dreq = 1'b1;
            repeat (2) @(negedge clk);
            wr_dreq = 1'b0;
            check("stray_dreq_hold", wr_data, w_exp);
            d = slow ? 200 : int'($urandom_range(0, 4));
            sink_waiting = 1'b1;
            repeat (d) @(negedge clk);
            wr_done = 1'b1;
            @(negedge clk);
            wr_done = 1'b0;
            sink_waiting = 1'b0;
            check("frame_done_timing", 32'(frame_done), 32'(last));
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_read_en"},    32'(read_en),    0);
        check({tag, "_wr_req"},     32'(wr_req),     0);
        check({tag, "_frame_done"}, 32'(frame_done), 0);
        check({tag, "_busy"},       32'(busy),       0);
        check({tag, "_wr_addr"},    32'(wr_addr),    0);
        check({tag, "_wr_data"},    wr_data,         0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (frame_done === 1'b1) frames_seen++;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        int activity;
        rst = 1'b1; aquire = 1'b0; cam_data = '0; cam_row = '0;
        wr_ack = 1'b0; wr_dreq = 1'b0; wr_done = 1'b0;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst = 1'b0;
        @(negedge clk);

        // Full frame, first request acknowledged after 7 cycles.
        fork
            upstream_run(V, 0);
            sink_run(V * NB, 7, 1'b0, 0);
        join
        check("frames_after_first", frames_seen, exp_frames);

        // Slow commit: reading overlaps the drain only with two banks.
        reads_in_wait = 0;
        fork
            upstream_run(V, 0);
            sink_run(V * NB, 0, 1'b1, 0);
        join
`ifdef LBW_PINGPONG_EN
        check("read_during_drain", 32'(reads_in_wait > 0), 1);
`else
        check("read_during_drain", 32'(reads_in_wait > 0), 0);
`endif
        check("frames_after_slow", frames_seen, exp_frames);

        // Reset in the middle of a burst, then a clean line.
        fork
            upstream_run(1, 2);
            sink_run(1, 0, 1'b0, 8);
        join
        rst = 1'b1;
        @(negedge clk);
        check_all_zero("mid_rst");
        rst = 1'b0;
        exp_addr_q.delete();
        exp_last_q.delete();
        exp_word_q.delete();
        activity = 0;
        repeat (20) begin
            @(negedge clk);
            if (wr_req || read_en || busy) activity++;
        end
        check("idle_after_rst", activity, 0);

        fork
            upstream_run(1, 1);
            sink_run(NB, 2, 1'b0, 0);
        join
        repeat (5) @(negedge clk);
        check("frames_final", frames_seen, exp_frames);
        check("bursts_outstanding", exp_addr_q.size(), 0);
        check("words_outstanding", exp_word_q.size(), 0);
        check("busy_at_end", 32'(busy), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/line_burst_writer.md
LINE_BURST_WRITER -- requirements
Module: line_burst_writer

Interface
REQ-001 SHALL have parameter H_ACT, default 1280, meaning pixels per line; H_ACT SHALL be a multiple of 2*BURST_LEN.
REQ-002 SHALL have parameter V_ACT, default 720, meaning lines per frame.
REQ-003 SHALL have parameter BURST_LEN, default 16, meaning 32-bit words per memory burst.
REQ-004 SHALL have parameter BASE_ADDR, default 0, meaning byte address of pixel (0,0).
REQ-005 SHALL have ports: clk in 1, the single clock for all logic; rst in 1, asynchronous active-high reset.
REQ-006 SHALL have ports: aquire in 1, line data available upstream; read_en out 1, pixel pop; cam_data in 16, RGB565 pixel, valid the cycle after read_en; cam_row in 11, upstream row index.
REQ-007 SHALL have ports: wr_req out 1, burst request; wr_addr out 28, burst byte address; wr_ack in 1, request accepted; wr_dreq in 1, sink pulls one word; wr_data out 32, word, valid the cycle after wr_dreq; wr_done in 1, burst committed.
REQ-008 SHALL have ports: frame_done out 1, one-cycle pulse after the last burst of row V_ACT-1 completes; busy out 1, any bank full or any FSM not idle.

Function
REQ-009 Read FSM SHALL use states R_IDLE, R_LINE and R_COMMIT.
REQ-010 R_IDLE->R_LINE SHALL occur when aquire=1 and a free bank exists; cam_row SHALL be latched into that bank's row tag.
REQ-011 In R_LINE, read_en SHALL be high for exactly H_ACT consecutive cycles with no gap, because upstream advances its row on a 2-cycle read_en gap.
REQ-012 Pixel 2k SHALL go to word bits [15:0] and pixel 2k+1 to bits [31:16]; word k SHALL be written to bank address k (H_ACT/2 words per bank).
REQ-013 R_COMMIT SHALL follow the cycle after the last captured pixel, mark the bank full, and return to R_IDLE in one cycle.
REQ-014 Write FSM SHALL use states W_IDLE, W_REQ, W_DATA and W_WAIT, and SHALL drain full banks in fill order.
REQ-015 W_IDLE->W_REQ SHALL occur when the oldest bank is full; wr_req SHALL be held with a stable wr_addr until it is sampled together with wr_ack.
REQ-016 wr_addr SHALL equal BASE_ADDR + 2*(row*H_ACT + b*2*BURST_LEN) for burst b = 0..H_ACT/(2*BURST_LEN)-1, computed modulo 2^28.
REQ-017 W_DATA SHALL return one word per wr_dreq cycle, and SHALL move to W_WAIT after BURST_LEN words.
REQ-018 On wr_done, W_WAIT SHALL go to W_REQ for the next burst; after the last burst it SHALL free the bank and go to W_IDLE.
REQ-019 frame_done SHALL pulse when a freed bank carried row tag V_ACT-1.
REQ-020 If a bank frees in the same cycle that the read FSM requests a bank, the freed bank SHALL be usable on the next cycle; no pixel SHALL be lost.
REQ-021 If wr_dreq is asserted outside W_DATA or beyond BURST_LEN words, it SHALL be ignored and wr_data SHALL hold its value.

Reset
REQ-022 On rst, read_en, wr_req, frame_done and busy SHALL be 0; wr_addr and wr_data SHALL be 0; all banks SHALL be empty; both FSMs SHALL be idle.
REQ-023 An rst mid-line or mid-burst SHALL abort immediately; the pending burst SHALL be abandoned without wr_req re-assertion.

Configuration
REQ-024 With LBW_PINGPONG_EN defined, two banks SHALL exist and a line SHALL be read while the other bank drains.
REQ-025 Without LBW_PINGPONG_EN, one bank SHALL exist and R_IDLE SHALL wait until it is freed; all port behaviour is otherwise identical.

Structure
REQ-026 A shared package lbw_pkg SHALL hold the read and write state enums, the word width (32) and the address width (28).
REQ-027 Bank storage SHALL be one sub-module lbw_line_ram: a simple dual-port RAM of H_ACT/2 x 32 per bank with 1-cycle read latency.

Verification
REQ-028 Reset, then aquire=1 with cam_row=5 and pixels 0..1279 -> read_en high for 1280 consecutive cycles; first wr_addr = BASE+12800; 40 bursts of 16 words; first wr_data = {pix1,pix0}.
REQ-029 wr_ack delayed 7 cycles -> wr_req and wr_addr stay stable for all 7 cycles; exactly one burst is accepted.
REQ-030 Rows 0..719 streamed -> a single frame_done pulse, 1 cycle after wr_done of burst 39 of row 719.
REQ-031 With PINGPONG, a slow sink (wr_done 200 cycles late) -> row n+1 is read during the drain of row n; without PINGPONG, read_en stays low until row n is freed.
REQ-032 rst asserted mid-burst at word 8 -> all outputs are 0 the next cycle; a fresh line after release starts at burst 0.
REQ-033 Stray wr_dreq in W_WAIT -> wr_data is unchanged and the word count is unaffected.
